// File: rtl/ahb3lite_interconnect_master_port_if.sv
// Bus bundle between one AHB3-Lite master and its interconnect master port.
// The slave modport is the port block's view; the master modport is the opposite side.
interface ahb3lite_interconnect_master_port_if #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int SLAVES     = 8
);
   logic                  mst_HSEL;
   logic                  mst_HWRITE;
   logic                  mst_HMASTLOCK;
   logic                  mst_HREADY;
   logic [HADDR_SIZE-1:0] mst_HADDR;
   logic [HDATA_SIZE-1:0] mst_HWDATA;
   logic [2:0]            mst_HSIZE;
   logic [2:0]            mst_HBURST;
   logic [3:0]            mst_HPROT;
   logic [1:0]            mst_HTRANS;
   logic [HDATA_SIZE-1:0] mst_HRDATA;
   logic                  mst_HREADYOUT;
   logic                  mst_HRESP;

   logic [HADDR_SIZE-1:0] slvHADDRbase [SLAVES];
   logic [HADDR_SIZE-1:0] slvHADDRmask [SLAVES];
   logic [SLAVES-1:0]     slvHSEL;
   logic [HADDR_SIZE-1:0] slvHADDR;
   logic [HDATA_SIZE-1:0] slvHWDATA;
   logic                  slvHWRITE;
   logic [2:0]            slvHSIZE;
   logic [2:0]            slvHBURST;
   logic [3:0]            slvHPROT;
   logic [1:0]            slvHTRANS;
   logic                  slvHMASTLOCK;
   logic                  slvHREADY;
   logic [HDATA_SIZE-1:0] slvHRDATA [SLAVES];
   logic [SLAVES-1:0]     slvHREADYOUT;
   logic [SLAVES-1:0]     slvHRESP;
   logic [SLAVES-1:0]     granted;
   logic [SLAVES-1:0]     can_switch;

   modport slave (
      input  mst_HSEL, mst_HWRITE, mst_HMASTLOCK, mst_HREADY, mst_HADDR, mst_HWDATA,
             mst_HSIZE, mst_HBURST, mst_HPROT, mst_HTRANS,
             slvHADDRbase, slvHADDRmask, slvHRDATA, slvHREADYOUT, slvHRESP, granted,
      output mst_HRDATA, mst_HREADYOUT, mst_HRESP,
             slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT,
             slvHTRANS, slvHMASTLOCK, slvHREADY, can_switch
   );

   modport master (
      output mst_HSEL, mst_HWRITE, mst_HMASTLOCK, mst_HREADY, mst_HADDR, mst_HWDATA,
             mst_HSIZE, mst_HBURST, mst_HPROT, mst_HTRANS,
             slvHADDRbase, slvHADDRmask, slvHRDATA, slvHREADYOUT, slvHRESP, granted,
      input  mst_HRDATA, mst_HREADYOUT, mst_HRESP,
             slvHSEL, slvHADDR, slvHWDATA, slvHWRITE, slvHSIZE, slvHBURST, slvHPROT,
             slvHTRANS, slvHMASTLOCK, slvHREADY, can_switch
   );
endinterface

// File: rtl/ahb3lite_interconnect_master_port.sv
// AHB3-Lite interconnect master port: address decode, grant wait/hold, data-phase response mux.
// Define AHB3LITE_INTERCONNECT_DEFAULT_SLAVE_ERROR_EN to answer unmapped transfers with a two-cycle ERROR.
module ahb3lite_interconnect_master_port #(
   parameter int HADDR_SIZE = 32,
   parameter int HDATA_SIZE = 32,
   parameter int SLAVES     = 8
) (
   input logic HRESETn,
   input logic HCLK,
   ahb3lite_interconnect_master_port_if.slave bus
);
   localparam int SW = (SLAVES > 1) ? $clog2(SLAVES) : 1;
   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

`ifdef AHB3LITE_INTERCONNECT_DEFAULT_SLAVE_ERROR_EN
   typedef enum logic [1:0] {IDLE, WAIT_GRANT, ERR1, ERR2} state_t;
`else
   typedef enum logic {IDLE, WAIT_GRANT} state_t;
`endif

   state_t                state_reg, state_next;
   logic [HADDR_SIZE-1:0] haddr_reg, haddr_next;
   logic                  hwrite_reg, hwrite_next;
   logic [2:0]            hsize_reg, hsize_next;
   logic [2:0]            hburst_reg, hburst_next;
   logic [3:0]            hprot_reg, hprot_next;
   logic [1:0]            htrans_reg, htrans_next;
   logic                  hmastlock_reg, hmastlock_next;
   logic [SW-1:0]         hold_sel_reg, hold_sel_next;
   logic                  dsel_valid_reg, dsel_valid_next;
   logic [SW-1:0]         dsel_reg, dsel_next;

   logic [SLAVES-1:0]     hit;
   logic [SLAVES-1:0]     can_sw;
   logic                  mapped;
   logic [SW-1:0]         dec_sel;
   logic                  accept;
   logic                  grant_dec;
   logic                  hold_ready;
   logic                  in_wait;
   logic                  addr_live;
   logic                  resp_ready;
   logic                  resp_err;
   logic [HDATA_SIZE-1:0] resp_rdata;

   genvar gi;
   generate
      for (gi = 0; gi < SLAVES; gi++) begin : g_slave
         assign hit[gi] = bus.mst_HSEL &
                          ((bus.mst_HADDR & bus.slvHADDRmask[gi]) ==
                           (bus.slvHADDRbase[gi] & bus.slvHADDRmask[gi]));
         assign can_sw[gi] = ~bus.mst_HMASTLOCK &
                             ((bus.mst_HTRANS == HTRANS_IDLE) | (bus.mst_HTRANS == HTRANS_NONSEQ)) &
                             ~(in_wait & (hold_sel_reg == SW'(gi)));
      end
   endgenerate

   // Lowest-numbered matching slave wins overlapping windows.
   always_comb begin
      mapped  = 1'b0;
      dec_sel = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
         if (hit[s]) begin
            mapped  = 1'b1;
            dec_sel = SW'(s);
         end
      end
   end

   assign accept     = bus.mst_HREADY & bus.mst_HSEL & bus.mst_HTRANS[1];
   assign grant_dec  = bus.granted[dec_sel];
   assign hold_ready = bus.granted[hold_sel_reg] & bus.slvHREADYOUT[hold_sel_reg];
   assign in_wait    = (state_reg == WAIT_GRANT);
`ifdef AHB3LITE_INTERCONNECT_DEFAULT_SLAVE_ERROR_EN
   assign addr_live  = (state_reg == IDLE) | (state_reg == ERR2);
`else
   assign addr_live  = (state_reg == IDLE);
`endif

   always_comb begin
      state_next      = state_reg;
      haddr_next      = haddr_reg;
      hwrite_next     = hwrite_reg;
      hsize_next      = hsize_reg;
      hburst_next     = hburst_reg;
      hprot_next      = hprot_reg;
      htrans_next     = htrans_reg;
      hmastlock_next  = hmastlock_reg;
      hold_sel_next   = hold_sel_reg;
      dsel_valid_next = dsel_valid_reg;
      dsel_next       = dsel_reg;
      if (state_reg == WAIT_GRANT) begin
         if (hold_ready) begin
            state_next      = IDLE;
            dsel_valid_next = 1'b1;
            dsel_next       = hold_sel_reg;
         end
      end
`ifdef AHB3LITE_INTERCONNECT_DEFAULT_SLAVE_ERROR_EN
      else if (state_reg == ERR1) begin
         state_next = ERR2;
      end
`endif
      else begin
         state_next = IDLE;
         if (bus.mst_HREADY) begin
            dsel_valid_next = 1'b0;
            if (accept) begin
               if (mapped && grant_dec) begin
                  dsel_valid_next = 1'b1;
                  dsel_next       = dec_sel;
               end else if (mapped) begin
                  state_next     = WAIT_GRANT;
                  haddr_next     = bus.mst_HADDR;
                  hwrite_next    = bus.mst_HWRITE;
                  hsize_next     = bus.mst_HSIZE;
                  hburst_next    = bus.mst_HBURST;
                  hprot_next     = bus.mst_HPROT;
                  htrans_next    = bus.mst_HTRANS;
                  hmastlock_next = bus.mst_HMASTLOCK;
                  hold_sel_next  = dec_sel;
               end
`ifdef AHB3LITE_INTERCONNECT_DEFAULT_SLAVE_ERROR_EN
               else begin
                  state_next = ERR1;
               end
`endif
            end
         end
      end
   end

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_reg      <= IDLE;
         haddr_reg      <= '0;
         hwrite_reg     <= 1'b0;
         hsize_reg      <= '0;
         hburst_reg     <= '0;
         hprot_reg      <= '0;
         htrans_reg     <= '0;
         hmastlock_reg  <= 1'b0;
         hold_sel_reg   <= '0;
         dsel_valid_reg <= 1'b0;
         dsel_reg       <= '0;
      end else begin
         state_reg      <= state_next;
         haddr_reg      <= haddr_next;
         hwrite_reg     <= hwrite_next;
         hsize_reg      <= hsize_next;
         hburst_reg     <= hburst_next;
         hprot_reg      <= hprot_next;
         htrans_reg     <= htrans_next;
         hmastlock_reg  <= hmastlock_next;
         hold_sel_reg   <= hold_sel_next;
         dsel_valid_reg <= dsel_valid_next;
         dsel_reg       <= dsel_next;
      end
   end

   // While waiting for a grant the held request is replayed; a held SEQ restarts a burst as NONSEQ.
   always_comb begin
      bus.slvHSEL = '0;
      if (in_wait) begin
         bus.slvHSEL[hold_sel_reg] = 1'b1;
      end else if (addr_live && mapped && grant_dec) begin
         bus.slvHSEL[dec_sel] = 1'b1;
      end
   end

   assign bus.slvHADDR     = in_wait ? haddr_reg     : bus.mst_HADDR;
   assign bus.slvHWRITE    = in_wait ? hwrite_reg    : bus.mst_HWRITE;
   assign bus.slvHSIZE     = in_wait ? hsize_reg     : bus.mst_HSIZE;
   assign bus.slvHBURST    = in_wait ? hburst_reg    : bus.mst_HBURST;
   assign bus.slvHPROT     = in_wait ? hprot_reg     : bus.mst_HPROT;
   assign bus.slvHMASTLOCK = in_wait ? hmastlock_reg : bus.mst_HMASTLOCK;
   assign bus.slvHTRANS    = !in_wait ? bus.mst_HTRANS :
                             (htrans_reg == HTRANS_SEQ) ? HTRANS_NONSEQ : htrans_reg;
   assign bus.slvHWDATA    = bus.mst_HWDATA;
   assign bus.can_switch   = can_sw;

   always_comb begin
      resp_rdata = '0;
      resp_ready = 1'b1;
      resp_err   = 1'b0;
      if (dsel_valid_reg) begin
         resp_rdata = bus.slvHRDATA[dsel_reg];
         resp_ready = bus.slvHREADYOUT[dsel_reg];
         resp_err   = bus.slvHRESP[dsel_reg];
      end
      if (state_reg == WAIT_GRANT) begin
         resp_ready = hold_ready;
         resp_err   = 1'b0;
      end
`ifdef AHB3LITE_INTERCONNECT_DEFAULT_SLAVE_ERROR_EN
      else if (state_reg == ERR1) begin
         resp_ready = 1'b0;
         resp_err   = 1'b1;
      end else if (state_reg == ERR2) begin
         resp_ready = 1'b1;
         resp_err   = 1'b1;
      end
`endif
   end

   assign bus.mst_HRDATA    = resp_rdata;
   assign bus.mst_HREADYOUT = resp_ready;
   assign bus.mst_HRESP     = resp_err;
   assign bus.slvHREADY     = resp_ready;
endmodule

// File: tb/tb_ahb3lite_interconnect_master_port.sv
// Self-checking bench: vector table for single-cycle decode/forwarding plus hand-written
// grant-wait, SEQ-hold, unmapped and reset-abort sequences; read data goes through a scoreboard.
module tb_ahb3lite_interconnect_master_port;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 8;
   localparam logic [1:0] T_IDLE = 2'b00, T_BUSY = 2'b01, T_NONSEQ = 2'b10, T_SEQ = 2'b11;

   logic HCLK = 1'b0;
   logic HRESETn = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 HCLK = ~HCLK;

   ahb3lite_interconnect_master_port_if #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS)) bus ();

   ahb3lite_interconnect_master_port #(.HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS)) dut (
      .HRESETn (HRESETn),
      .HCLK    (HCLK),
      .bus     (bus)
   );

   // Single-master system: the bus HREADY is this port's own HREADYOUT.
   assign bus.mst_HREADY = bus.mst_HREADYOUT;

   typedef struct packed {
      logic        hsel;
      logic [1:0]  htrans;
      logic        hwrite;
      logic        lock;
      logic [31:0] haddr;
      logic [31:0] hwdata;
      logic [7:0]  granted;
      logic [7:0]  exp_sel;
      logic [7:0]  exp_sw;
      logic [31:0] exp_rdata;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] rdata;
   } sb_t;

   vec_t vecs [10];
   sb_t  sb_q [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, exp);
      end else begin
         $display("ok   %s: %h", name, act);
      end
   endtask

   task automatic sb_push(input string name, input logic [31:0] rdata);
      sb_t e;
      e.name  = name;
      e.rdata = rdata;
      sb_q.push_back(e);
   endtask

   task automatic sb_pop();
      sb_t e;
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL sb_empty: got no entry required one");
      end else begin
         e = sb_q.pop_front();
         chk({e.name, "_rdata"}, bus.mst_HRDATA, e.rdata);
      end
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive_req(input logic hsel, input logic [1:0] htrans, input logic [31:0] haddr,
                            input logic [7:0] granted);
      bus.mst_HSEL      = hsel;
      bus.mst_HTRANS    = htrans;
      bus.mst_HADDR     = haddr;
      bus.mst_HWRITE    = 1'b0;
      bus.mst_HMASTLOCK = 1'b0;
      bus.mst_HWDATA    = '0;
      bus.granted       = granted;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: got no finish required finish before 100000");
      $fatal(1);
   end

   initial begin
      vecs[0] = '{1'b0, T_NONSEQ, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 8'hFF, 8'h00, 8'hFF, 32'h0};
      vecs[1] = '{1'b1, T_NONSEQ, 1'b0, 1'b0, 32'h0000_1000, 32'h0, 8'h01, 8'h01, 8'hFF, 32'hDEAD_BEEF};
      vecs[2] = '{1'b1, T_SEQ,    1'b0, 1'b0, 32'h0000_1004, 32'h0, 8'h01, 8'h01, 8'h00, 32'hDEAD_BEEF};
      vecs[3] = '{1'b1, T_NONSEQ, 1'b0, 1'b0, 32'h0003_0010, 32'h0, 8'hFF, 8'h08, 8'hFF, 32'hA500_0003};
      vecs[4] = '{1'b1, T_NONSEQ, 1'b0, 1'b0, 32'h0001_0000, 32'h0, 8'hFF, 8'h02, 8'hFF, 32'hA500_0001};
      vecs[5] = '{1'b1, T_IDLE,   1'b0, 1'b0, 32'h0002_0000, 32'h0, 8'hFF, 8'h04, 8'hFF, 32'h0};
      vecs[6] = '{1'b1, T_BUSY,   1'b0, 1'b0, 32'h0002_0000, 32'h0, 8'hFF, 8'h04, 8'h00, 32'h0};
      vecs[7] = '{1'b1, T_NONSEQ, 1'b0, 1'b1, 32'h0004_0000, 32'h0, 8'hFF, 8'h10, 8'h00, 32'hA500_0004};
      vecs[8] = '{1'b1, T_NONSEQ, 1'b1, 1'b0, 32'h0006_0000, 32'h1234_5678, 8'hFF, 8'h40, 8'hFF, 32'hA500_0006};
      vecs[9] = '{1'b0, T_IDLE,   1'b0, 1'b0, 32'h0000_0000, 32'h0, 8'hFF, 8'h00, 8'hFF, 32'h0};

      // Slave s owns 0x000s_xxxx; slave 7 overlaps slave 1 to exercise priority.
      for (int s = 0; s < NS; s++) begin
         bus.slvHADDRbase[s] = 32'(s) << 16;
         bus.slvHADDRmask[s] = 32'hFFFF_0000;
         bus.slvHRDATA[s]    = 32'hA500_0000 | 32'(s);
      end
      bus.slvHADDRbase[7] = 32'h0001_0000;
      bus.slvHRDATA[0]    = 32'hDEAD_BEEF;
      bus.slvHRDATA[2]    = 32'hA500_0002;
      bus.slvHREADYOUT    = '1;
      bus.slvHRESP        = '0;
      bus.mst_HSIZE       = 3'b010;
      bus.mst_HBURST      = 3'b000;
      bus.mst_HPROT       = 4'b0011;
      drive_req(1'b0, T_IDLE, 32'h0, 8'h00);

      // Reset state
      @(negedge HCLK);
      chk("rst_hreadyout", 32'(bus.mst_HREADYOUT), 32'h1);
      chk("rst_hresp", 32'(bus.mst_HRESP), 32'h0);
      chk("rst_slvhsel", 32'(bus.slvHSEL), 32'h0);
      cyc();
      HRESETn = 1'b1;
      sb_push("reset", 32'h0);

      // Table: address-phase forwarding, decode, can_switch; data phase via scoreboard
      for (int i = 0; i < 10; i++) begin
         bus.mst_HSEL      = vecs[i].hsel;
         bus.mst_HTRANS    = vecs[i].htrans;
         bus.mst_HWRITE    = vecs[i].hwrite;
         bus.mst_HMASTLOCK = vecs[i].lock;
         bus.mst_HADDR     = vecs[i].haddr;
         bus.mst_HWDATA    = vecs[i].hwdata;
         bus.granted       = vecs[i].granted;
         @(negedge HCLK);
         chk($sformatf("vec%0d_slvhsel", i), 32'(bus.slvHSEL), 32'(vecs[i].exp_sel));
         chk($sformatf("vec%0d_can_switch", i), 32'(bus.can_switch), 32'(vecs[i].exp_sw));
         chk($sformatf("vec%0d_slvhaddr", i), bus.slvHADDR, vecs[i].haddr);
         chk($sformatf("vec%0d_slvhtrans", i), 32'(bus.slvHTRANS), 32'(vecs[i].htrans));
         chk($sformatf("vec%0d_slvhwrite", i), 32'(bus.slvHWRITE), 32'(vecs[i].hwrite));
         chk($sformatf("vec%0d_slvhwdata", i), bus.slvHWDATA, vecs[i].hwdata);
         chk($sformatf("vec%0d_hreadyout", i), 32'(bus.mst_HREADYOUT), 32'h1);
         sb_pop();
         sb_push($sformatf("vec%0d", i), vecs[i].exp_rdata);
         cyc();
      end
      @(negedge HCLK);
      sb_pop();
      cyc();

      // Read to slave 0 with grant withheld for three cycles
      drive_req(1'b1, T_NONSEQ, 32'h0000_1000, 8'h00);
      @(negedge HCLK);
      chk("wait_pre_slvhsel", 32'(bus.slvHSEL), 32'h0);
      cyc();
      drive_req(1'b1, T_IDLE, 32'h0000_2000, 8'h00);
      for (int w = 0; w < 3; w++) begin
         @(negedge HCLK);
         chk($sformatf("wait%0d_hreadyout", w), 32'(bus.mst_HREADYOUT), 32'h0);
         chk($sformatf("wait%0d_slvhaddr", w), bus.slvHADDR, 32'h0000_1000);
         chk($sformatf("wait%0d_slvhsel", w), 32'(bus.slvHSEL), 32'h01);
         chk($sformatf("wait%0d_can_switch0", w), 32'(bus.can_switch[0]), 32'h0);
         cyc();
      end
      bus.granted = 8'h01;
      @(negedge HCLK);
      chk("grant_hreadyout", 32'(bus.mst_HREADYOUT), 32'h1);
      chk("grant_slvhtrans", 32'(bus.slvHTRANS), 32'(T_NONSEQ));
      chk("grant_slvhaddr", bus.slvHADDR, 32'h0000_1000);
      sb_push("wait_read", 32'hDEAD_BEEF);
      cyc();
      drive_req(1'b0, T_IDLE, 32'h0, 8'hFF);
      @(negedge HCLK);
      sb_pop();
      cyc();

      // SEQ to ungranted slave 2 is replayed as NONSEQ
      drive_req(1'b1, T_SEQ, 32'h0002_0004, 8'h00);
      cyc();
      drive_req(1'b1, T_IDLE, 32'h0002_0008, 8'h00);
      @(negedge HCLK);
      chk("seqhold_slvhtrans", 32'(bus.slvHTRANS), 32'(T_NONSEQ));
      chk("seqhold_slvhsel", 32'(bus.slvHSEL), 32'h04);
      chk("seqhold_hreadyout", 32'(bus.mst_HREADYOUT), 32'h0);
      cyc();
      bus.granted = 8'h04;
      @(negedge HCLK);
      chk("seqhold_grant_hreadyout", 32'(bus.mst_HREADYOUT), 32'h1);
      sb_push("seqhold", 32'hA500_0002);
      cyc();
      drive_req(1'b0, T_IDLE, 32'h0, 8'hFF);
      @(negedge HCLK);
      sb_pop();
      cyc();

      // Unmapped NONSEQ
      drive_req(1'b1, T_NONSEQ, 32'hF000_0000, 8'hFF);
      @(negedge HCLK);
      chk("unmap_slvhsel", 32'(bus.slvHSEL), 32'h0);
      chk("unmap_pre_hreadyout", 32'(bus.mst_HREADYOUT), 32'h1);
      cyc();
      drive_req(1'b0, T_IDLE, 32'h0, 8'hFF);
`ifdef AHB3LITE_INTERCONNECT_DEFAULT_SLAVE_ERROR_EN
      @(negedge HCLK);
      chk("err1_hreadyout", 32'(bus.mst_HREADYOUT), 32'h0);
      chk("err1_hresp", 32'(bus.mst_HRESP), 32'h1);
      cyc();
      @(negedge HCLK);
      chk("err2_hreadyout", 32'(bus.mst_HREADYOUT), 32'h1);
      chk("err2_hresp", 32'(bus.mst_HRESP), 32'h1);
      cyc();
      @(negedge HCLK);
      chk("err_done_hreadyout", 32'(bus.mst_HREADYOUT), 32'h1);
      chk("err_done_hresp", 32'(bus.mst_HRESP), 32'h0);
`else
      @(negedge HCLK);
      chk("unmap_hreadyout", 32'(bus.mst_HREADYOUT), 32'h1);
      chk("unmap_hresp", 32'(bus.mst_HRESP), 32'h0);
      sb_push("unmap", 32'h0);
      sb_pop();
`endif
      cyc();

      // Reset pulse while waiting for a grant abandons the transfer
      drive_req(1'b1, T_NONSEQ, 32'h0000_1000, 8'h00);
      cyc();
      drive_req(1'b0, T_IDLE, 32'h0, 8'h00);
      @(negedge HCLK);
      chk("rstwait_hreadyout", 32'(bus.mst_HREADYOUT), 32'h0);
      #2;
      HRESETn = 1'b0;
      #1;
      chk("rstpulse_hreadyout", 32'(bus.mst_HREADYOUT), 32'h1);
      chk("rstpulse_slvhsel", 32'(bus.slvHSEL), 32'h0);
      chk("rstpulse_hresp", 32'(bus.mst_HRESP), 32'h0);
      cyc();
      cyc();
      HRESETn = 1'b1;
      bus.granted = 8'hFF;
      for (int k = 0; k < 3; k++) begin
         @(negedge HCLK);
         chk($sformatf("post_rst%0d_slvhsel", k), 32'(bus.slvHSEL), 32'h0);
         chk($sformatf("post_rst%0d_hreadyout", k), 32'(bus.mst_HREADYOUT), 32'h1);
         cyc();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ahb3lite_interconnect_master_port.md
AHB3LITE_INTERCONNECT_MASTER_PORT -- requirements
Module: ahb3lite_interconnect_master_port

Interface
REQ-001 Parameter HADDR_SIZE SHALL default to 32 and set the address width.
REQ-002 Parameter HDATA_SIZE SHALL default to 32 and set the data width.
REQ-003 Parameter SLAVES SHALL default to 8 and set the number of slave ports addressable from this master.
REQ-004 Ports SHALL be (name, direction, width, meaning):
- HRESETn, in, 1, asynchronous active-low reset.
- HCLK, in, 1, clock; all state on the rising edge.
- mst_HSEL/HWRITE/HMASTLOCK/HREADY, in, 1 each, AHB master request; HREADY is the bus HREADY.
- mst_HADDR, in, HADDR_SIZE, address.
- mst_HWDATA, in, HDATA_SIZE, write data.
- mst_HSIZE/HBURST/HPROT/HTRANS, in, 3/3/4/2, transfer attributes.
- mst_HRDATA, out, HDATA_SIZE, read data to master.
- mst_HREADYOUT/HRESP, out, 1 each, response to master.
- slvHADDRbase, in, [SLAVES][HADDR_SIZE], slave base addresses.
- slvHADDRmask, in, [SLAVES][HADDR_SIZE], slave address masks.
- slvHSEL, out, SLAVES, per-slave-port select.
- slvHADDR/HWDATA/HWRITE/HSIZE/HBURST/HPROT/HTRANS/HMASTLOCK, out, as mst_*, forwarded request.
- slvHREADY, out, 1, bus HREADY to all slave ports.
- slvHRDATA, in, [SLAVES][HDATA_SIZE], per-slave-port read data.
- slvHREADYOUT/slvHRESP, in, SLAVES each, per-slave-port response.
- granted, in, SLAVES, bit s high when slave port s has granted this master.
- can_switch, out, SLAVES, bit s high when slave port s may re-arbitrate away from this master.

Function
REQ-005 Decode SHALL be: hit[s] = mst_HSEL & ((mst_HADDR & mask[s]) == (base[s] & mask[s])); lowest hit index wins; no hit = unmapped.
REQ-006 Address phase accepted when mst_HREADY=1, mst_HSEL=1, HTRANS NONSEQ or SEQ.
REQ-007 If accepted to slave s with granted[s]=1, signals SHALL pass combinationally, slvHSEL one-hot on s.
REQ-008 If accepted to slave s with granted[s]=0, all address-phase signals SHALL latch into hold registers, FSM enters WAIT_GRANT, mst_HREADYOUT=0.
REQ-009 In WAIT_GRANT outputs SHALL come from hold registers with slvHSEL[s]=1; held SEQ SHALL be driven as NONSEQ.
REQ-010 WAIT_GRANT SHALL exit to IDLE on the first edge with granted[s]=1 and slvHREADYOUT[s]=1; data-phase select then = s.
REQ-011 Data-phase select register SHALL update only when the address phase completes; mst_HRDATA/HREADYOUT/HRESP muxed from it.
REQ-012 FSM states SHALL be IDLE, WAIT_GRANT, ERR1, ERR2.
REQ-013 Accepted unmapped transfer SHALL go IDLE->ERR1 (HREADYOUT=0, HRESP=1) ->ERR2 (HREADYOUT=1, HRESP=1) ->IDLE.
REQ-014 IDLE/BUSY or mst_HSEL=0 SHALL get OKAY, zero wait, HRDATA=0 when no slave selected.
REQ-015 can_switch[s] SHALL be ~mst_HMASTLOCK & (HTRANS==IDLE | HTRANS==NONSEQ), forced 0 for the held slave in WAIT_GRANT.
REQ-016 slvHREADY SHALL equal mst_HREADYOUT; slvHWDATA SHALL equal mst_HWDATA unregistered.
REQ-017 New request during WAIT_GRANT SHALL be ignored (master stalled by HREADYOUT=0).

Reset
REQ-018 HRESETn low SHALL asynchronously set FSM=IDLE, hold registers=0, data-phase select=none, giving mst_HREADYOUT=1, mst_HRESP=0, slvHSEL=0.
REQ-019 Reset during WAIT_GRANT or ERR1/ERR2 SHALL abandon the transfer with no response.

Configuration
REQ-020 Macro AHB3LITE_INTERCONNECT_DEFAULT_SLAVE_ERROR_EN defined: REQ-013 applies; undefined: unmapped transfers SHALL complete OKAY, zero wait, HRDATA=0, and ERR1/ERR2 SHALL not exist.

Verification
REQ-021 Master NONSEQ read 0x0000_1000, slave 0 base 0x0, mask 0xFFFF_0000, granted[0]=1 -> slvHSEL=0x01 same cycle; slave returns 0xDEADBEEF, mst_HRDATA=0xDEADBEEF.
REQ-022 Same access, granted[0]=0 for 3 cycles -> mst_HREADYOUT=0 for 3 cycles, held address stable; completes the cycle granted[0] rises.
REQ-023 SEQ to ungranted slave 2 -> slvHTRANS=NONSEQ (2'b10) while held.
REQ-024 NONSEQ to unmapped 0xF000_0000 with macro defined -> HREADYOUT 0,1 with HRESP 1,1; macro undefined -> HREADYOUT=1, HRESP=0.
REQ-025 HRESETn pulsed low during WAIT_GRANT -> mst_HREADYOUT=1, slvHSEL=0 immediately, no transfer issued after release.
